// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared constants and types for the MMC3 scanline IRQ block: CPU register
// decode values, save-state address map and the A12 filter default.
package mmc3_scanline_irq_pkg;

    // CPU register select = {cpu_addr[14:13], cpu_addr[0]}
    localparam logic [2:0] REG_C000 = 3'b100;
    localparam logic [2:0] REG_C001 = 3'b101;
    localparam logic [2:0] REG_E000 = 3'b110;
    localparam logic [2:0] REG_E001 = 3'b111;

    // Save-state address map
    localparam logic [7:0] SS_BASE  = 8'd16;
    localparam logic [7:0] SS_CNT   = SS_BASE;
    localparam logic [7:0] SS_LATCH = SS_BASE + 8'd1;
    localparam logic [7:0] SS_FLAGS = SS_BASE + 8'd2;
    localparam logic [7:0] SS_FILT  = SS_BASE + 8'd3;

    // M2 falls A12 must stay low before a rise is accepted
    localparam int FILT_M2_DEF = 3;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] latch;
        logic       reload;
        logic       en;
        logic       pend;
    } irq_state_t;

    // Save-state flags byte layout
    function automatic logic [7:0] pack_flags(input irq_state_t s);
        return {5'b0, s.reload, s.en, s.pend};
    endfunction

endpackage

// File: rtl/mmc3_a12_filter.sv
// PPU A12 synchronizer and low-time filter. A rising edge of the
// synchronized A12 produces a one-clk qualified pulse only after A12 has
// been low for FILT_M2 M2 falling edges.
module mmc3_a12_filter
    import mmc3_scanline_irq_pkg::*;
#(
    parameter int FILT_M2 = FILT_M2_DEF
) (
    input  logic       clk,
    input  logic       map_rst_n,
    input  logic       i_ppu_a12,
    input  logic       i_m2_fall,
    input  logic       i_ss_act,
    input  logic       i_ss_load,
    input  logic [7:0] i_ss_val,
    output logic       o_qual,
    output logic [7:0] o_filt_cnt
);

    localparam logic [7:0] L_FILT = 8'(FILT_M2);

    logic       r_a12_s1;
    logic       r_a12_s2;
    logic       r_a12_d;
    logic [7:0] r_filt;
    logic       r_qual;
    logic       w_rise;

    assign w_rise     = r_a12_s2 & ~r_a12_d;
    assign o_qual     = r_qual;
    assign o_filt_cnt = r_filt;

    // Synchronize A12, count low M2 periods, register the qualified edge
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            r_a12_s1 <= 1'b0;
            r_a12_s2 <= 1'b0;
            r_a12_d  <= 1'b0;
            r_filt   <= 8'd0;
            r_qual   <= 1'b0;
        end else begin
            r_a12_s1 <= i_ppu_a12;
            r_a12_s2 <= r_a12_s1;
            r_a12_d  <= r_a12_s2;
            // qualification uses the count as it stood before this rise
            r_qual   <= w_rise & (r_filt == L_FILT) & ~i_ss_act;
            if (i_ss_load) begin
                r_filt <= i_ss_val;
            end else if (!i_ss_act) begin
                if (r_a12_s2) begin
                    r_filt <= 8'd0;
                end else if (i_m2_fall && (r_filt < L_FILT)) begin
                    r_filt <= r_filt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline counter and IRQ. CPU register writes are taken on the
// synchronized M2 fall; the counter is clocked by filtered PPU A12 rises.
// Build option: define MMC3_IRQ_SS_EN for save-state readback/load of the
// counter, latch, flags and filter count; otherwise ss_dout reads 8'hFF.
module mmc3_scanline_irq
    import mmc3_scanline_irq_pkg::*;
#(
    parameter int FILT_M2 = FILT_M2_DEF
) (
    input  logic        clk,
    input  logic        map_rst_n,
    input  logic        m2,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic        ppu_a12,
    input  logic        mmc3a,
    input  logic        ss_act,
    input  logic        ss_we,
    input  logic [7:0]  ss_addr,
    output logic [7:0]  ss_dout,
    output logic        irq
);

    logic       r_m2_s1;
    logic       r_m2_s2;
    logic       r_m2_d;
    irq_state_t r_st;
    irq_state_t w_nxt;
    logic       w_m2_fall;
    logic       w_cpu_wr;
    logic [2:0] w_sel;
    logic       w_qual;
    logic       w_edge;
    logic [7:0] w_filt_cnt;
    logic       w_ss_load;
    logic [7:0] w_ss_val;
    logic       w_unused;

    assign w_m2_fall = r_m2_d & ~r_m2_s2;
    assign w_cpu_wr  = w_m2_fall & ~cpu_rw & cpu_addr[15] & ~ss_act;
    assign w_sel     = {cpu_addr[14:13], cpu_addr[0]};
    assign w_edge    = w_qual & ~ss_act;
    assign irq       = r_st.pend;
    assign w_unused  = ^{cpu_addr[12:1], ss_we, ss_addr, w_filt_cnt};

`ifdef MMC3_IRQ_SS_EN
    assign w_ss_load = w_m2_fall & ss_we & (ss_addr == SS_FILT);
    assign w_ss_val  = cpu_dat;
`else
    assign w_ss_load = 1'b0;
    assign w_ss_val  = 8'h00;
`endif

    mmc3_a12_filter #(
        .FILT_M2 (FILT_M2)
    ) u_a12_filter (
        .clk        (clk),
        .map_rst_n  (map_rst_n),
        .i_ppu_a12  (ppu_a12),
        .i_m2_fall  (w_m2_fall),
        .i_ss_act   (ss_act),
        .i_ss_load  (w_ss_load),
        .i_ss_val   (w_ss_val),
        .o_qual     (w_qual),
        .o_filt_cnt (w_filt_cnt)
    );

    // Next state: the A12 edge sees pre-write state, then writes override
    always_comb begin
        w_nxt = r_st;
        if (w_edge) begin
            if ((r_st.cnt == 8'd0) || r_st.reload) begin
                w_nxt.cnt    = r_st.latch;
                w_nxt.reload = 1'b0;
            end else begin
                w_nxt.cnt = r_st.cnt - 8'd1;
            end
            // old silicon only fires when the counter actually reached zero
            if ((w_nxt.cnt == 8'd0) && r_st.en &&
                (!mmc3a || (r_st.cnt != 8'd0) || r_st.reload)) begin
                w_nxt.pend = 1'b1;
            end
        end
        if (w_cpu_wr) begin
            case (w_sel)
                REG_C000: w_nxt.latch = cpu_dat;
                REG_C001: begin
                    w_nxt.cnt    = 8'd0;
                    w_nxt.reload = 1'b1;
                end
                REG_E000: begin
                    w_nxt.en   = 1'b0;
                    w_nxt.pend = 1'b0;
                end
                REG_E001: w_nxt.en = 1'b1;
                default: ;
            endcase
        end
`ifdef MMC3_IRQ_SS_EN
        if (w_m2_fall && ss_we) begin
            case (ss_addr)
                SS_CNT:   w_nxt.cnt   = cpu_dat;
                SS_LATCH: w_nxt.latch = cpu_dat;
                SS_FLAGS: begin
                    w_nxt.reload = cpu_dat[2];
                    w_nxt.en     = cpu_dat[1];
                    w_nxt.pend   = cpu_dat[0];
                end
                default: ;
            endcase
        end
`endif
    end

    // M2 synchronizer and IRQ state registers
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            r_m2_s1 <= 1'b0;
            r_m2_s2 <= 1'b0;
            r_m2_d  <= 1'b0;
            r_st    <= '0;
        end else begin
            r_m2_s1 <= m2;
            r_m2_s2 <= r_m2_s1;
            r_m2_d  <= r_m2_s2;
            r_st    <= w_nxt;
        end
    end

    // Save-state readback
    always_comb begin
        ss_dout = 8'hFF;
`ifdef MMC3_IRQ_SS_EN
        case (ss_addr)
            SS_CNT:   ss_dout = r_st.cnt;
            SS_LATCH: ss_dout = r_st.latch;
            SS_FLAGS: ss_dout = pack_flags(r_st);
            SS_FILT:  ss_dout = w_filt_cnt;
            default:  ss_dout = 8'hFF;
        endcase
`endif
    end

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Self-checking bench for mmc3_scanline_irq: a behavioural model produces
// expected irq/counter values that are queued when stimulus is driven and
// compared once the documented latency has elapsed.
module tb_mmc3_scanline_irq;

    logic        clk = 1'b0;
    logic        map_rst_n = 1'b0;
    logic        m2 = 1'b1;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dat = 8'h00;
    logic        ppu_a12 = 1'b1;
    logic        mmc3a = 1'b0;
    logic        ss_act = 1'b0;
    logic        ss_we = 1'b0;
    logic [7:0]  ss_addr = 8'h00;
    logic [7:0]  ss_dout;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [7:0] irq;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb[$];

    // behavioural model state
    logic [7:0] m_cnt, m_latch;
    logic       m_reload, m_en, m_pend;

    mmc3_scanline_irq #(.FILT_M2(3)) dut (
        .clk       (clk),
        .map_rst_n (map_rst_n),
        .m2        (m2),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_dat   (cpu_dat),
        .ppu_a12   (ppu_a12),
        .mmc3a     (mmc3a),
        .ss_act    (ss_act),
        .ss_we     (ss_we),
        .ss_addr   (ss_addr),
        .ss_dout   (ss_dout),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 8'd0; m_latch = 8'd0; m_reload = 1'b0; m_en = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] pre_c;
        logic       pre_r;
        pre_c = m_cnt;
        pre_r = m_reload;
        if (m_cnt == 8'd0 || m_reload) begin
            m_cnt = m_latch;
            m_reload = 1'b0;
        end else begin
            m_cnt = m_cnt - 8'd1;
        end
        if (m_cnt == 8'd0 && m_en && (!mmc3a || pre_c != 8'd0 || pre_r))
            m_pend = 1'b1;
    endtask

    task automatic model_write(input logic [15:0] addr, input logic [7:0] dat);
        logic [2:0] sel;
        sel = {addr[14:13], addr[0]};
        if (addr[15]) begin
            case (sel)
                3'b100: m_latch = dat;
                3'b101: begin m_cnt = 8'd0; m_reload = 1'b1; end
                3'b110: begin m_en = 1'b0; m_pend = 1'b0; end
                3'b111: m_en = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic sb_push(input string tag);
        exp_t e;
        e.tag = tag;
        e.irq = {7'b0, m_pend};
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_irq"}, {7'b0, irq}, e.irq);
`ifdef MMC3_IRQ_SS_EN
            chk({e.tag, "_cnt"}, ss_dout, e.cnt);
`endif
        end
    endtask

    task automatic m2_cycle();
        @(negedge clk) m2 = 1'b0;
        repeat (3) @(negedge clk);
        m2 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] dat, input string tag);
        logic pre;
        @(negedge clk);
        cpu_addr = addr; cpu_dat = dat; cpu_rw = 1'b0;
        @(negedge clk);
        m2 = 1'b0;
        pre = m_pend;
        if (!ss_act) model_write(addr, dat);
        sb_push(tag);
        repeat (2) @(posedge clk);
        #1 chk({tag, "_lat"}, {7'b0, irq}, {7'b0, pre});
        @(posedge clk);
        #1 sb_pop_check();
        @(negedge clk);
        m2 = 1'b1; cpu_rw = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // A12 low for n M2 falls, then a rise; expects A12 high on entry
    task automatic a12_edge(input int n, input string tag);
        logic pre;
        @(negedge clk) ppu_a12 = 1'b0;
        repeat (3) @(negedge clk);
        repeat (n) m2_cycle();
        @(negedge clk) ppu_a12 = 1'b1;
        pre = m_pend;
        if (n >= 3 && !ss_act) model_edge();
        sb_push(tag);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_lat"}, {7'b0, irq}, {7'b0, pre});
        @(posedge clk);
        #1 sb_pop_check();
        repeat (2) @(negedge clk);
    endtask

    // Qualified A12 edge and a CPU write landing in the same clk
    task automatic edge_with_write(input logic [15:0] addr, input logic [7:0] dat, input string tag);
        logic pre;
        @(negedge clk) ppu_a12 = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) m2_cycle();
        @(negedge clk);
        cpu_addr = addr; cpu_dat = dat; cpu_rw = 1'b0; ppu_a12 = 1'b1;
        @(negedge clk) m2 = 1'b0;
        pre = m_pend;
        model_edge();
        model_write(addr, dat);
        sb_push(tag);
        repeat (2) @(posedge clk);
        #1 chk({tag, "_lat"}, {7'b0, irq}, {7'b0, pre});
        @(posedge clk);
        #1 sb_pop_check();
        @(negedge clk);
        m2 = 1'b1; cpu_rw = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk) map_rst_n = 1'b0;
        #1 chk({tag, "_irq_async"}, {7'b0, irq}, 8'd0);
        model_reset();
        repeat (2) @(negedge clk);
        map_rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ss_we = 1'b1; ss_addr = a; cpu_dat = d; cpu_rw = 1'b1;
        @(negedge clk) m2 = 1'b0;
        repeat (4) @(negedge clk);
        ss_we = 1'b0; m2 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_irq", {7'b0, irq}, 8'd0);
        chk("rst_ss_dout", ss_dout, 8'hFF);
        repeat (3) @(negedge clk);
        map_rst_n = 1'b1;
        repeat (4) @(negedge clk);
`ifdef MMC3_IRQ_SS_EN
        ss_addr = 8'd16;
`else
        ss_addr = 8'd16;
        #1 chk("ss_dout_const", ss_dout, 8'hFF);
`endif

        // Counting 2,1,0,2,1 with IRQ at zero, then acknowledge
        cpu_write(16'hC000, 8'd2, "b_c000");
        cpu_write(16'hC001, 8'd0, "b_c001");
        cpu_write(16'hE001, 8'd0, "b_e001");
        for (int i = 0; i < 5; i++) a12_edge(3, $sformatf("b_edge%0d", i));
        cpu_write(16'hE000, 8'd0, "b_e000");

        // Short A12 low time is filtered out
        cpu_write(16'hE001, 8'd0, "f_e001");
        for (int i = 0; i < 3; i++) a12_edge(2, $sformatf("f_short%0d", i));
        a12_edge(3, "f_long");

        // Save-state active: writes and edges ignored
        ss_act = 1'b1;
        cpu_write(16'hE000, 8'd0, "s_e000_ign");
        a12_edge(3, "s_edge_ign");
        ss_act = 1'b0;
        cpu_write(16'hE000, 8'd0, "s_e000");

        // latch = 0: new mode fires on every edge, old mode only once
        for (int mode = 0; mode < 2; mode++) begin
            mmc3a = mode[0];
            do_reset($sformatf("z%0d_rst", mode));
            cpu_write(16'hC000, 8'd0, $sformatf("z%0d_c000", mode));
            cpu_write(16'hC001, 8'd0, $sformatf("z%0d_c001", mode));
            cpu_write(16'hE001, 8'd0, $sformatf("z%0d_e001", mode));
            a12_edge(3, $sformatf("z%0d_edge0", mode));
            for (int k = 1; k < 3; k++) begin
                cpu_write(16'hE000, 8'd0, $sformatf("z%0d_ack%0d", mode, k));
                cpu_write(16'hE001, 8'd0, $sformatf("z%0d_en%0d", mode, k));
                a12_edge(3, $sformatf("z%0d_edge%0d", mode, k));
            end
        end
        mmc3a = 1'b0;

        // Same-clk qualified edge and E000 with counter = 1
        do_reset("c_rst");
        cpu_write(16'hC000, 8'd1, "c_c000");
        cpu_write(16'hC001, 8'd0, "c_c001");
        cpu_write(16'hE001, 8'd0, "c_e001");
        a12_edge(3, "c_edge_load");
        edge_with_write(16'hE000, 8'd0, "c_edge_e000");
        a12_edge(3, "c_edge_reload");
        a12_edge(3, "c_edge_noen");

        // Reset mid-count with IRQ pending
        do_reset("r_pre");
        cpu_write(16'hC000, 8'd0, "r_c000a");
        cpu_write(16'hC001, 8'd0, "r_c001");
        cpu_write(16'hE001, 8'd0, "r_e001");
        a12_edge(3, "r_edge0");
        cpu_write(16'hC000, 8'd5, "r_c000b");
        a12_edge(3, "r_edge5");
        do_reset("r_mid");
`ifdef MMC3_IRQ_SS_EN
        for (int a = 16; a < 20; a++) begin
            ss_addr = 8'(a);
            #1 chk($sformatf("r_ss%0d", a), ss_dout, 8'd0);
        end
        ss_addr = 8'd16;
`endif
        cpu_write(16'hE001, 8'd0, "r_e001b");
        a12_edge(3, "r_edge_after");

`ifdef MMC3_IRQ_SS_EN
        // Save-state load then resume counting
        cpu_write(16'hE000, 8'd0, "ss_ack");
        ss_act = 1'b1;
        ss_write(8'd16, 8'h07);
        ss_write(8'd18, 8'h02);
        m_cnt = 8'd7; m_reload = 1'b0; m_en = 1'b1; m_pend = 1'b0;
        ss_addr = 8'd16;
        #1 chk("ss_rb_cnt", ss_dout, 8'h07);
        ss_addr = 8'd18;
        #1 chk("ss_rb_flags", ss_dout, 8'h02);
        ss_addr = 8'd16;
        ss_act = 1'b0;
        for (int i = 0; i < 7; i++) a12_edge(3, $sformatf("ss_edge%0d", i));
`endif

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
